// File: rtl/euler_pkg.sv
// Shared types and constants for the Euler result BCD formatter and its
// double-dabble engine.
package euler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT,
    NEWLINE
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam int         RESULT_W      = 24;
  localparam int         RESULT_DIGITS = 8;

  function automatic logic [7:0] digit_char(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/euler_result_bcd_if.sv
// Byte-stream valid/ready channel carrying the ASCII result to a console sink.
interface euler_result_bcd_if;

  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);

endinterface

// File: rtl/euler_bin2bcd.sv
// Sequential double-dabble engine: one bit per clock after start_i.
// done_o flags the final step; bcd_o is the completed value only while done_o is high.
module euler_bin2bcd
  import euler_pkg::*;
#(
  parameter int BIN_W  = RESULT_W,
  parameter int DIGITS = RESULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                run_q;

  // Per-digit add-3 with no carry between digits, then a joint left shift;
  // the bit leaving the top of the accumulator is always zero.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {acc_d, shift_d} = {acc_adj, shift_q} << 1;
  end

  assign done_o = run_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = acc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      shift_q <= bin_i;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/euler_result_bcd.sv
// Captures the Euler sum on the rising done flag, converts to BCD and streams ASCII + LF.
// Define EULER_BCD_LZS_EN to suppress leading zeros in the character stream.
module euler_result_bcd
  import euler_pkg::*;
#(
  parameter int BIN_W  = RESULT_W,
  parameter int DIGITS = RESULT_DIGITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 results_valid,
  input  logic [BIN_W-1:0]     results,
  output logic [4*DIGITS-1:0]  bcd,
  output logic                 bcd_valid,
  output logic                 busy,
  output logic                 dropped,
  euler_result_bcd_if.master   char_if
);

  localparam int IDX_W = $clog2(DIGITS);

  state_t              state_q;
  logic                results_valid_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                bcd_valid_q;
  logic [7:0]          char_data_q;
  logic                char_valid_q;
  logic                busy_q;
  logic                dropped_q;

  logic                trig;
  logic                conv_start;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [IDX_W-1:0]    start_idx;
  logic [IDX_W-1:0]    idx_dec;
  logic                transfer;

  assign trig       = results_valid & ~results_valid_q;
  assign conv_start = trig && (state_q == IDLE);
  assign transfer   = char_valid_q & char_if.char_ready;
  assign idx_dec    = idx_q - IDX_W'(1);

  euler_bin2bcd #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (conv_start),
    .bin_i   (results),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // First digit to emit, chosen from the freshly completed conversion.
  always_comb begin
`ifdef EULER_BCD_LZS_EN
    start_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (conv_bcd[4*i +: 4] != 4'd0) begin
        start_idx = IDX_W'(i);
      end
    end
`else
    start_idx = IDX_W'(DIGITS - 1);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      results_valid_q <= 1'b0;
      idx_q           <= '0;
      bcd_q           <= '0;
      bcd_valid_q     <= 1'b0;
      char_data_q     <= '0;
      char_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      dropped_q       <= 1'b0;
    end else begin
      results_valid_q <= results_valid;
      if (trig && (state_q != IDLE)) begin
        dropped_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (trig) begin
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            bcd_q        <= conv_bcd;
            bcd_valid_q  <= 1'b1;
            idx_q        <= start_idx;
            char_data_q  <= digit_char(conv_bcd[4*start_idx +: 4]);
            char_valid_q <= 1'b1;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          if (transfer) begin
            if (idx_q == '0) begin
              char_data_q <= ASCII_LF;
              state_q     <= NEWLINE;
            end else begin
              idx_q       <= idx_dec;
              char_data_q <= digit_char(bcd_q[4*idx_dec +: 4]);
            end
          end
        end
        NEWLINE: begin
          if (transfer) begin
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd                = bcd_q;
  assign bcd_valid          = bcd_valid_q;
  assign busy               = busy_q;
  assign dropped            = dropped_q;
  assign char_if.char_data  = char_data_q;
  assign char_if.char_valid = char_valid_q;

endmodule

// File: tb/tb_euler_result_bcd.sv
// Directed bench for euler_result_bcd; expected streams follow EULER_BCD_LZS_EN.
module tb_euler_result_bcd;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        results_valid = 1'b0;
  logic [23:0] results = '0;
  logic [31:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        dropped;

  euler_result_bcd_if cif ();

  euler_result_bcd dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .results_valid (results_valid),
    .results       (results),
    .bcd           (bcd),
    .bcd_valid     (bcd_valid),
    .busy          (busy),
    .dropped       (dropped),
    .char_if       (cif)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  byte unsigned exp_q[$];
  logic [7:0]  lfsr = 8'hA5;
  bit          aborted;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Decimal model of the expected character stream.
  task automatic gen_exp(input int unsigned v);
    int unsigned p;
    int unsigned d;
    bit started;
    exp_q.delete();
    started = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      d = (v / p) % 10;
`ifdef EULER_BCD_LZS_EN
      if (d != 0 || started || i == 0) begin
        started = 1'b1;
        exp_q.push_back(8'(8'h30 + d));
      end
`else
      exp_q.push_back(8'(8'h30 + d));
`endif
    end
    exp_q.push_back(8'h0A);
  endtask

  // Called just before the capture edge.
  task automatic measure_conv(input logic [31:0] exp_bcd);
    int n;
    @(posedge clk); #1;
    chk("bcd_valid_clr", {31'd0, bcd_valid}, 32'd0);
    chk("busy_set", {31'd0, busy}, 32'd1);
    n = 0;
    while (!bcd_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("conv_latency", n, 24);
    chk("bcd_value", bcd, exp_bcd);
  endtask

  task automatic start_capture(input logic [23:0] v, input logic [31:0] exp_bcd);
    @(negedge clk);
    results       = v;
    results_valid = 1'b1;
    measure_conv(exp_bcd);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    results_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // mode 0: always ready, 1: pseudo-random ready.
  // action 1: retrigger after two bytes, 2: reset while the third byte is offered.
  task automatic collect(input int mode, input int action, output bit ab);
    byte unsigned got[$];
    int cyc;
    bit stall;
    logic [7:0] held;
    int stall_err;
    int phase;
    bit done;
    cyc = 0; stall = 0; held = '0; stall_err = 0; phase = 0; done = 0; ab = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (stall && (!cif.char_valid || cif.char_data !== held)) stall_err++;
      if (action == 2 && got.size() == 2 && cif.char_valid) begin
        reset_n = 1'b0;
        #1;
        chk("rst_bcd", bcd, 32'd0);
        chk("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        chk("rst_char_valid", {31'd0, cif.char_valid}, 32'd0);
        chk("rst_char_data", {24'd0, cif.char_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dropped", {31'd0, dropped}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ab = 1'b1;
        return;
      end
      if (action == 1) begin
        if (phase == 0 && got.size() == 2) begin
          results_valid = 1'b0;
          phase = 1;
        end else if (phase == 1) begin
          results       = 24'd999;
          results_valid = 1'b1;
          phase = 2;
        end
      end
      if (mode == 1) begin
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        cif.char_ready = lfsr[0];
      end else begin
        cif.char_ready = 1'b1;
      end
      if (cif.char_valid && cif.char_ready) begin
        got.push_back(cif.char_data);
        stall = 1'b0;
        if (cif.char_data == 8'h0A) done = 1'b1;
      end else if (cif.char_valid) begin
        stall = 1'b1;
        held  = cif.char_data;
      end else begin
        stall = 1'b0;
      end
    end
    chk("stream_done", {31'd0, done}, 32'd1);
    chk("stream_len", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("char%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(exp_q[i]));
    end
    chk("stall_stable", stall_err, 0);
    @(posedge clk); #1;
    chk("end_char_valid", {31'd0, cif.char_valid}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    cif.char_ready = 1'b1;
  endtask

  initial begin
    int active;
    cif.char_ready = 1'b1;
    #1;
    chk("reset_bcd", bcd, 32'd0);
    chk("reset_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    chk("reset_char_data", {24'd0, cif.char_data}, 32'd0);
    chk("reset_char_valid", {31'd0, cif.char_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dropped", {31'd0, dropped}, 32'd0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    gen_exp(233168);
    start_capture(24'd233168, 32'h00233168);
    collect(0, 0, aborted);
    chk("t1_dropped", {31'd0, dropped}, 32'd0);
    idle_gap();

    gen_exp(0);
    start_capture(24'd0, 32'h00000000);
    collect(0, 0, aborted);
    idle_gap();

    gen_exp(16777215);
    start_capture(24'd16777215, 32'h16777215);
    collect(0, 0, aborted);
    idle_gap();

    gen_exp(233168);
    start_capture(24'd233168, 32'h00233168);
    collect(1, 0, aborted);
    chk("t4_dropped", {31'd0, dropped}, 32'd0);
    idle_gap();

    gen_exp(233168);
    start_capture(24'd233168, 32'h00233168);
    collect(0, 1, aborted);
    chk("t5_dropped", {31'd0, dropped}, 32'd1);
    active = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cif.char_valid || busy) active++;
    end
    chk("t5_no_second", active, 0);
    chk("t5_bcd_kept", bcd, 32'h00233168);
    chk("t5_bcd_valid_kept", {31'd0, bcd_valid}, 32'd1);
    idle_gap();

    gen_exp(233168);
    start_capture(24'd233168, 32'h00233168);
    collect(0, 2, aborted);
    chk("t6_aborted", {31'd0, aborted}, 32'd1);
    measure_conv(32'h00233168);
    collect(0, 0, aborted);
    chk("t6_dropped", {31'd0, dropped}, 32'd0);
    idle_gap();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/euler_result_bcd.md
Name: euler_result_bcd

Overview:
- Downstream consumer of the Euler problem-1 accumulator. It captures the 24-bit binary sum when the accumulator's done flag rises.
- Converts the sum to 8 BCD digits using sequential double-dabble, one bit per clock.
- Streams the decimal result as ASCII characters over a valid/ready byte interface, terminated by a newline, for a UART/console sink.
- Also exposes the packed BCD value for debug.

Parameters:
- BIN_W, 24, width of binary input; fixed max value 16,777,215.
- DIGITS, 8, BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- results_valid  in  1  upstream done flag; level, stays high until upstream reset.
- results  in  BIN_W  upstream sum; stable while results_valid is high.
- bcd  out  4*DIGITS  packed BCD; digit 0 in [3:0].
- bcd_valid  out  1  high while bcd holds a completed conversion.
- char_data  out  8  ASCII character.
- char_valid  out  1  character available.
- char_ready  in  1  sink accepts.
- busy  out  1  high in CONVERT/EMIT/NEWLINE.
- dropped  out  1  sticky; a capture edge arrived while busy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: bcd=0, bcd_valid=0, char_data=0, char_valid=0, busy=0, dropped=0, FSM=IDLE, results_valid_q=0.
- Capture trigger: results_valid & !results_valid_q, where results_valid_q is a one-cycle delayed copy.
  - A level held high gives exactly one capture.
  - results_valid already high out of reset captures on the first clock.
- IDLE: on trigger, load shift reg = results and BCD accumulator = 0, set bit_cnt = 0, clear bcd_valid, go to CONVERT.
- CONVERT, one double-dabble step per clock:
  - Each digit >= 5 gets +3 first.
  - Then shift {bcd_acc, shift_reg} left by 1.
  - After the BIN_W-th step, register bcd, set bcd_valid=1, set digit index to DIGITS-1 and go to EMIT.
  - Capture at edge C gives bcd_valid high after edge C+24.
- EMIT:
  - char_data = 8'h30 + current digit; char_valid=1.
  - On char_valid & char_ready, decrement the index. After digit 0 transfers, go to NEWLINE.
  - char_data and char_valid must stay stable while char_valid & !char_ready.
  - char_valid never drops without a transfer.
- NEWLINE: char_data = 8'h0A; on transfer, char_valid=0 and go to IDLE. bcd and bcd_valid persist until the next capture.
- Trigger while busy: ignored, current output unaffected, dropped set to 1. dropped clears only on reset.
- Trigger in the same cycle as the final newline transfer: counts as busy, so it is dropped.
- Reset mid-operation: immediate return to reset values; no partial character is held; the sink sees char_valid drop asynchronously.
- Arithmetic: the add-3 correction is per 4-bit digit with no carry between digits. The accumulator is 4*DIGITS bits and the top shifted-out bit is discarded, which cannot overflow given the parameter rule.

Optional Feature:
- EULER_BCD_LZS_EN defined: leading-zero suppression.
  - EMIT starts at the most significant non-zero digit, found in the cycle the conversion completes.
  - A value of 0 emits the single character "0".
- Not defined: all DIGITS digits are emitted, including leading zeros, e.g. "00233168".
- bcd and bcd_valid behave identically in both cases.

Decomposition:
- Shared package euler_pkg holds:
  - FSM state enum {IDLE, CONVERT, EMIT, NEWLINE}.
  - Constants ASCII_ZERO=8'h30, ASCII_LF=8'h0A, RESULT_W=24, RESULT_DIGITS=8.
- One natural sub-module, euler_bin2bcd: the sequential double-dabble engine with start/done, bin in, bcd out.
- The top level keeps the edge detect, FSM and byte stream.

Test Plan:
1. results=233168, results_valid rises, char_ready=1:
   - bcd=32'h00233168, bcd_valid high 24 clocks after capture.
   - Chars 0x32,0x33,0x33,0x31,0x36,0x38,0x0A with LZS_EN.
   - With LZS_EN off: 0x30,0x30 first, then the same sequence.
2. results=0 -> bcd=0; chars "0\n" with LZS_EN; "00000000\n" without.
3. results=16777215 -> bcd=32'h16777215; chars "16777215\n" (identical with or without the macro).
4. Backpressure: 233168 with char_ready toggling pseudo-randomly -> identical character sequence; char_data stable during every stall; no duplicate or lost bytes.
5. Second trigger mid-EMIT (results_valid dropped and re-raised with 999) -> first stream completes unchanged; dropped=1; no second stream.
6. reset_n pulsed low during the third character -> all outputs return to reset values immediately. A subsequent capture of 233168 then produces the full correct stream.
